// File: rtl/alu_pkg.sv
// Shared datapath widths, opcode encodings and helpers for the ALU, the decoder and the issue stage.
// The bypass selector lives here so every operand port resolves forwarding the same way.
package alu_pkg;

    localparam int unsigned DW     = 16;
    localparam int unsigned NREG   = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned OPW    = 4;

    typedef logic [DW-1:0]     data_t;
    typedef logic [REG_AW-1:0] reg_t;
    typedef logic [OPW-1:0]    op_t;

    localparam op_t OP_ADD   = 4'd0;
    localparam op_t OP_SUB   = 4'd1;
    localparam op_t OP_AND   = 4'd2;
    localparam op_t OP_OR    = 4'd3;
    localparam op_t OP_XOR   = 4'd4;
    localparam op_t OP_NOR   = 4'd5;
    localparam op_t OP_SLL   = 4'd6;
    localparam op_t OP_SRL   = 4'd7;
    localparam op_t OP_SRA   = 4'd8;
    localparam op_t OP_SLT   = 4'd9;
    localparam op_t OP_SLTU  = 4'd10;
    localparam op_t OP_PASSA = 4'd11;
    localparam op_t OP_PASSB = 4'd12;
    localparam op_t OP_INC   = 4'd13;
    localparam op_t OP_DEC   = 4'd14;
    localparam op_t OP_NOT   = 4'd15;

    function automatic data_t alu_eval(op_t op, data_t a, data_t b);
        data_t r;
        r = '0;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOR:   r = ~(a | b);
            OP_SLL:   r = a << b[3:0];
            OP_SRL:   r = a >> b[3:0];
            OP_SRA:   r = data_t'($signed(a) >>> b[3:0]);
            OP_SLT:   r = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  r = {{(DW-1){1'b0}}, a < b};
            OP_PASSA: r = a;
            OP_PASSB: r = b;
            OP_INC:   r = a + data_t'(1);
            OP_DEC:   r = a - data_t'(1);
            OP_NOT:   r = ~a;
            default:  r = '0;
        endcase
        return r;
    endfunction

    // r0 never forwards; the younger (EX) producer wins over WB.
    function automatic data_t bypass_sel(reg_t src, logic ex_valid, reg_t ex_rd, data_t ex_val,
                                         logic wb_valid, reg_t wb_rd, data_t wb_val,
                                         data_t rf_val);
        data_t r;
        if (src != '0 && ex_valid && ex_rd == src) begin
            r = ex_val;
        end else if (src != '0 && wb_valid && wb_rd == src) begin
            r = wb_val;
        end else begin
            r = rf_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-side handshake, ALU operand/result bus and writeback handshake of the issue stage.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic  in_valid;
    logic  in_ready;
    op_t   in_op;
    reg_t  in_rs;
    reg_t  in_rt;
    reg_t  in_rd;
    logic  in_use_imm;
    data_t in_imm;
    data_t alu_a;
    data_t alu_b;
    op_t   alu_op;
    data_t alu_ans;
    logic  out_valid;
    logic  out_ready;
    reg_t  out_rd;
    data_t out_data;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_use_imm, in_imm, alu_ans, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_rd, out_data
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_use_imm, in_imm, alu_ans, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_rd, out_data
    );

endinterface

// File: rtl/alu.sv
// Purely combinational 16-bit ALU driven by the issue stage's registered EX operands.
module alu
    import alu_pkg::*;
(
    input  op_t   op_i,
    input  data_t a_i,
    input  data_t b_i,
    output data_t ans_o
);

    assign ans_o = alu_eval(op_i, a_i, b_i);

endmodule

// File: rtl/regfile_8x16.sv
// Architectural register file: two asynchronous read ports, one synchronous write port, r0 tied
// to zero. Reads return the word being written on the same edge.
module regfile_8x16
    import alu_pkg::*;
#(
    parameter int unsigned DW   = alu_pkg::DW,
    parameter int unsigned NREG = alu_pkg::NREG
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  reg_t          waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  reg_t          raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  reg_t          raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && waddr_i != '0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = mem_q[raddr_a_i];
        rdata_b_o = mem_q[raddr_b_i];
        if (we_i && waddr_i == raddr_a_i) rdata_a_o = wdata_i;
        if (we_i && waddr_i == raddr_b_i) rdata_b_o = wdata_i;
        if (raddr_a_i == '0) rdata_a_o = '0;
        if (raddr_b_i == '0) rdata_b_o = '0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue -> EX -> WB wrapper around the external combinational ALU, with full EX/WB forwarding so
// dependent instructions never stall; only writeback backpressure holds the pipe.
module alu_issue_stage #(
    parameter int unsigned DW   = alu_pkg::DW,
    parameter int unsigned NREG = alu_pkg::NREG
) (
    input logic               clk,
    input logic               rst,
    alu_issue_stage_if.slave  bus
);
    import alu_pkg::*;

    logic          stall;
    logic          accept;
    logic          rf_we;
    logic [DW-1:0] rf_rs;
    logic [DW-1:0] rf_rt;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;

    logic          ex_valid_q;
    reg_t          ex_rd_q;
    logic [DW-1:0] alu_a_q;
    logic [DW-1:0] alu_b_q;
    op_t           alu_op_q;
    logic          out_valid_q;
    reg_t          out_rd_q;
    logic [DW-1:0] out_data_q;

    assign stall  = out_valid_q & ~bus.out_ready;
    assign accept = bus.in_valid & ~stall;
    assign rf_we  = out_valid_q & bus.out_ready & (out_rd_q != '0);

    regfile_8x16 #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (rf_we),
        .waddr_i   (out_rd_q),
        .wdata_i   (out_data_q),
        .raddr_a_i (bus.in_rs),
        .rdata_a_o (rf_rs),
        .raddr_b_i (bus.in_rt),
        .rdata_b_o (rf_rt)
    );

    always_comb begin
        op_a = bypass_sel(bus.in_rs, ex_valid_q, ex_rd_q, bus.alu_ans,
                          out_valid_q, out_rd_q, out_data_q, rf_rs);
        op_b = bus.in_use_imm ? bus.in_imm
                              : bypass_sel(bus.in_rt, ex_valid_q, ex_rd_q, bus.alu_ans,
                                           out_valid_q, out_rd_q, out_data_q, rf_rt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
        end else if (!stall) begin
            ex_valid_q <= accept;
            // Operands stay put on a bubble so the ALU inputs do not toggle needlessly.
            if (accept) begin
                alu_a_q  <= op_a;
                alu_b_q  <= op_b;
                alu_op_q <= bus.in_op;
                ex_rd_q  <= bus.in_rd;
            end
            out_valid_q <= ex_valid_q;
            out_rd_q    <= ex_rd_q;
            out_data_q  <= bus.alu_ans;
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with the real ALU attached; a scoreboard queue is filled on
// accept and drained by a monitor on every writeback handshake.
module tb_alu_issue_stage;
    import alu_pkg::*;

    typedef struct packed {
        reg_t  rd;
        data_t data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    alu_issue_stage #(
        .DW   (16),
        .NREG (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu u_alu (
        .op_i  (bus.alu_op),
        .a_i   (bus.alu_a),
        .b_i   (bus.alu_b),
        .ans_o (bus.alu_ans)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    exp_t  sb_q[$];
    bit    sb_en = 1'b1;
    string cur_name;
    data_t exp_a, exp_b, exp_res;
    op_t   exp_op;
    reg_t  exp_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Writeback monitor: every out handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no writeback",
                         bus.out_rd, bus.out_data);
            end else begin
                e = sb_q.pop_front();
                check("wb_rd", 32'(bus.out_rd), 32'(e.rd));
                check("wb_data", 32'(bus.out_data), 32'(e.data));
            end
        end
    end

    task automatic drive(input string name, input op_t op, input reg_t rs, input reg_t rt,
                         input reg_t rd, input logic use_imm, input data_t imm,
                         input data_t ea, input data_t eb, input data_t eres);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_rs      = rs;
        bus.in_rt      = rt;
        bus.in_rd      = rd;
        bus.in_use_imm = use_imm;
        bus.in_imm     = imm;
        cur_name = name;
        exp_op   = op;
        exp_rd   = rd;
        exp_a    = ea;
        exp_b    = eb;
        exp_res  = eres;
    endtask

    task automatic wait_accept();
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready) begin
            k++;
            if (k > 20) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_accept_timeout: got in_ready=0 for 20 cycles, expected 1",
                         cur_name);
                $fatal(1, "accept wait expired");
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic post();
        if (sb_en) sb_q.push_back('{rd: exp_rd, data: exp_res});
        #1;
        check({cur_name, "_a"}, 32'(bus.alu_a), 32'(exp_a));
        check({cur_name, "_b"}, 32'(bus.alu_b), 32'(exp_b));
        check({cur_name, "_op"}, 32'(bus.alu_op), 32'(exp_op));
    endtask

    task automatic issue(input string name, input op_t op, input reg_t rs, input reg_t rt,
                         input reg_t rd, input logic use_imm, input data_t imm,
                         input data_t ea, input data_t eb, input data_t eres);
        drive(name, op, rs, rt, rd, use_imm, imm, ea, eb, eres);
        wait_accept();
        post();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive("rst_in", OP_PASSB, 3'd0, 3'd0, 3'd1, 1'b1, 16'hFFFF, 16'h0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        idle(1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        // Cleared registers read back as zero.
        issue("rf_zero", OP_ADD, 3'd5, 3'd6, 3'd7, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h0000);
        idle(3);

        // Immediate issue and two-cycle latency.
        issue("imm1", OP_PASSB, 3'd0, 3'd0, 3'd1, 1'b1, 16'h8010, 16'h0000, 16'h8010, 16'h8010);
        check("lat_imm1_empty", 32'(bus.out_valid), 32'd0);
        issue("imm2", OP_PASSB, 3'd0, 3'd0, 3'd2, 1'b1, 16'h0008, 16'h0000, 16'h0008, 16'h0008);
        check("lat_imm1_valid", 32'(bus.out_valid), 32'd1);
        check("lat_imm1_rd", 32'(bus.out_rd), 32'd1);
        idle(1);
        check("lat_imm2_valid", 32'(bus.out_valid), 32'd1);
        check("lat_imm2_rd", 32'(bus.out_rd), 32'd2);
        idle(1);
        check("lat_drained", 32'(bus.out_valid), 32'd0);

        // EX bypass, WB bypass, EX-over-WB priority, then plain register reads.
        issue("add_r3", OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0, 16'h8010, 16'h0008, 16'h8018);
        issue("ex_byp", OP_SUB, 3'd3, 3'd0, 3'd4, 1'b1, 16'h0018, 16'h8018, 16'h0018, 16'h8000);
        issue("wb_byp", OP_XOR, 3'd2, 3'd3, 3'd5, 1'b0, 16'h0, 16'h0008, 16'h8018, 16'h8010);
        issue("w6_old", OP_PASSB, 3'd0, 3'd0, 3'd6, 1'b1, 16'h1111, 16'h0000, 16'h1111, 16'h1111);
        issue("w6_new", OP_PASSB, 3'd0, 3'd0, 3'd6, 1'b1, 16'h2222, 16'h0000, 16'h2222, 16'h2222);
        issue("prio", OP_OR, 3'd6, 3'd0, 3'd7, 1'b0, 16'h0, 16'h2222, 16'h0000, 16'h2222);
        issue("rf_rd", OP_ADD, 3'd5, 3'd4, 3'd1, 1'b0, 16'h0, 16'h8010, 16'h8000, 16'h0010);
        idle(3);

        // Backpressure: WB held, pending input waits, then both move on one edge.
        bus.out_ready = 1'b0;
        issue("bp_inc", OP_INC, 3'd1, 3'd0, 3'd2, 1'b1, 16'h0, 16'h0010, 16'h0000, 16'h0011);
        issue("bp_dec", OP_DEC, 3'd2, 3'd0, 3'd3, 1'b1, 16'h0, 16'h0011, 16'h0000, 16'h0010);
        drive("bp_not", OP_NOT, 3'd1, 3'd0, 3'd4, 1'b1, 16'h0, 16'h0010, 16'h0000, 16'hFFEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_rd", 32'(bus.out_rd), 32'd2);
            check("bp_out_data", 32'(bus.out_data), 32'h0011);
            check("bp_alu_a", 32'(bus.alu_a), 32'h0011);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept();
        post();
        check("bp_rel_valid", 32'(bus.out_valid), 32'd1);
        check("bp_rel_rd", 32'(bus.out_rd), 32'd3);
        check("bp_rel_data", 32'(bus.out_data), 32'h0010);
        idle(4);

        // r0 is never written and never forwarded.
        issue("r0_wr", OP_PASSB, 3'd0, 3'd0, 3'd0, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF);
        issue("r0_ex", OP_ADD, 3'd0, 3'd0, 3'd5, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h0000);
        issue("r0_wb", OP_ADD, 3'd0, 3'd0, 3'd6, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h0000);
        idle(3);
        issue("r0_rf", OP_PASSA, 3'd0, 3'd0, 3'd7, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h0000);
        issue("sra", OP_SRA, 3'd4, 3'd0, 3'd1, 1'b1, 16'h0004, 16'hFFEF, 16'h0004, 16'hFFFE);
        issue("sltu", OP_SLTU, 3'd3, 3'd4, 3'd2, 1'b0, 16'h0, 16'h0010, 16'hFFEF, 16'h0001);
        idle(3);

        // Reset with EX and WB occupied: both are discarded.
        sb_en = 1'b0;
        issue("mid1", OP_PASSB, 3'd0, 3'd0, 3'd5, 1'b1, 16'hABCD, 16'h0000, 16'hABCD, 16'hABCD);
        issue("mid2", OP_PASSB, 3'd0, 3'd0, 3'd6, 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'h1234);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_en = 1'b1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("mid_rst_alu_b", 32'(bus.alu_b), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        issue("rf_clr", OP_ADD, 3'd4, 3'd5, 3'd1, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h0000);
        issue("rf_clr2", OP_OR, 3'd1, 3'd6, 3'd2, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h0000);
        idle(4);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
